// File: rtl/jk_chk_pkg.sv
// jk_chk_pkg: shared FSM states, error-code bit positions and the JK next-state rule
package jk_chk_pkg;
    typedef enum logic [1:0] {IDLE, SYNC, CHECK} state_e;
    localparam int ERR_Q_BIT  = 0;
    localparam int ERR_QB_BIT = 1;
    function automatic logic jk_next(input logic j, input logic k, input logic q);
        return (j && k) ? ~q : j ? 1'b1 : k ? 1'b0 : q;
    endfunction
endpackage

// File: rtl/jk_ff_checker_if.sv
// jk_ff_checker_if: stimulus/response bundle between a JK flip-flop bench and its checker
interface jk_ff_checker_if #(parameter int CNT_W = 8);
    logic             en;
    logic             j;
    logic             k;
    logic             q;
    logic             qb;
    logic             armed;
    logic             err;
    logic [1:0]       err_code;
    logic             err_sticky;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] check_count;
    modport master (
        output en, j, k, q, qb,
        input  armed, err, err_code, err_sticky, err_count, check_count
    );
    modport slave (
        input  en, j, k, q, qb,
        output armed, err, err_code, err_sticky, err_count, check_count
    );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: enable-increment counter that sticks at all-ones, async active-high clear
module sat_counter #(parameter int W = 8) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);
    logic [W-1:0] count_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) count_q <= '0;
        else if (inc_i && count_q != '1) count_q <= count_q + W'(1);
    assign count_o = count_q;
endmodule

// File: rtl/jk_ff_checker.sv
// jk_ff_checker: tracks a JK flip-flop with a reference model and flags transition/complement errors
module jk_ff_checker
    import jk_chk_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input logic             clk,
    input logic             rst,
    jk_ff_checker_if.slave  bus
);
    state_e     state_q, state_d;
    logic       exp_q, exp_d;
    logic       err_q;
    logic [1:0] err_code_q, code_d;
    logic       err_sticky_q;
    logic       chk_inc;
    // Predictions always start from the observed q so a single fault cannot cascade.
    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        code_d  = '0;
        chk_inc = 1'b0;
        case (state_q)
            IDLE: state_d = bus.en ? SYNC : IDLE;
            SYNC: begin
                code_d[ERR_QB_BIT] = bus.qb == bus.q;
                exp_d              = jk_next(bus.j, bus.k, bus.q);
                state_d            = CHECK;
            end
            CHECK: begin
                code_d[ERR_QB_BIT] = bus.qb == bus.q;
                code_d[ERR_Q_BIT]  = bus.q != exp_q;
                exp_d              = jk_next(bus.j, bus.k, bus.q);
                chk_inc            = 1'b1;
                state_d            = bus.en ? CHECK : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q      <= IDLE;
            exp_q        <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            exp_q        <= exp_d;
            err_q        <= |code_d;
            err_code_q   <= code_d;
            err_sticky_q <= err_sticky_q | (|code_d);
        end
    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (|code_d),
        .count_o (bus.err_count)
    );
    sat_counter #(.W(CNT_W)) u_chk_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (chk_inc),
        .count_o (bus.check_count)
    );
    assign bus.armed      = state_q == CHECK;
    assign bus.err        = err_q;
    assign bus.err_code   = err_code_q;
    assign bus.err_sticky = err_sticky_q;
endmodule

// File: tb/tb_jk_ff_checker.sv
// tb_jk_ff_checker: directed vectors against a behavioural JK flip-flop with fault knobs
module tb_jk_ff_checker;
    logic clk = 1'b0;
    logic rst;
    logic fq = 1'b1;
    logic stuck, qbeq;
    int   n_cmp = 0, n_bad = 0, errs;
    jk_ff_checker_if #(.CNT_W(8)) bus ();
    jk_ff_checker_if #(.CNT_W(3)) bus3 ();
    jk_ff_checker #(.CNT_W(8)) u_dut (.clk(clk), .rst(rst), .bus(bus));
    jk_ff_checker #(.CNT_W(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));
    always #5 clk = ~clk;
    // flip-flop under test: characteristic equation q+ = j~q | ~kq, no reset
    always @(posedge clk) fq <= (bus.j & ~fq) | (~bus.k & fq);
    assign bus.q   = stuck ? 1'b0 : fq;
    assign bus.qb  = qbeq ? bus.q : ~bus.q;
    assign bus3.j  = bus.j;
    assign bus3.k  = bus.k;
    assign bus3.q  = ~fq;
    assign bus3.qb = fq;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk_all_zero(input string tag);
        chk({tag, "_armed"}, bus.armed, 0);
        chk({tag, "_err"}, bus.err, 0);
        chk({tag, "_code"}, bus.err_code, 0);
        chk({tag, "_sticky"}, bus.err_sticky, 0);
        chk({tag, "_errcnt"}, bus.err_count, 0);
        chk({tag, "_chkcnt"}, bus.check_count, 0);
    endtask
    initial begin
        rst = 1'b1; bus.en = 1'b0; bus3.en = 1'b0; bus.j = 1'b0; bus.k = 1'b0;
        stuck = 1'b0; qbeq = 1'b0;
        step(); step();
        chk_all_zero("reset");
        rst = 1'b0; bus.en = 1'b1;
        step();
        chk("t1_armed_idle_edge", bus.armed, 0);
        errs = 0;
        for (int p = 0; p < 4; p++)
            for (int i = 0; i < 10; i++) begin
                bus.j = p[1]; bus.k = p[0];
                step();
                if (p == 0 && i == 0) chk("t1_armed_after_sync", bus.armed, 1);
                errs += int'(bus.err);
            end
        chk("t1_err_pulses", errs, 0);
        chk("t1_sticky", bus.err_sticky, 0);
        chk("t1_errcnt", bus.err_count, 0);
        chk("t1_chkcnt", bus.check_count, 39);
        chk("t1_armed", bus.armed, 1);
        bus.j = 1'b1; bus.k = 1'b0; stuck = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t2_err", bus.err, 1);
            chk("t2_code", bus.err_code, 1);
        end
        stuck = 1'b0;
        step();
        chk("t2_err_clear", bus.err, 0);
        chk("t2_errcnt", bus.err_count, 5);
        chk("t2_sticky", bus.err_sticky, 1);
        chk("t2_chkcnt", bus.check_count, 45);
        #3 rst = 1'b1;
        #1 chk_all_zero("async_rst");
        #1 rst = 1'b0; bus.j = 1'b0; bus.k = 1'b0;
        step();
        chk("rst_idle_edge_armed", bus.armed, 0);
        step();
        chk("rst_sync_armed", bus.armed, 1);
        chk("rst_sync_err", bus.err, 0);
        qbeq = 1'b1;
        step();
        chk("t3_qb_err", bus.err, 1);
        chk("t3_qb_code", bus.err_code, 2);
        qbeq = 1'b0;
        step();
        chk("t3_qb_clear", bus.err, 0);
        chk("t3_qb_errcnt", bus.err_count, 1);
        qbeq = 1'b1; stuck = 1'b1; bus.j = 1'b1;
        step();
        chk("t3_both_err", bus.err, 1);
        chk("t3_both_code", bus.err_code, 3);
        qbeq = 1'b0; stuck = 1'b0; bus.j = 1'b0;
        step();
        chk("t3_both_clear", bus.err, 0);
        chk("t3_errcnt", bus.err_count, 2);
        chk("t3_chkcnt", bus.check_count, 4);
        bus.en = 1'b0; bus.j = 1'b1; bus.k = 1'b1;
        step();
        chk("t4_drop_armed", bus.armed, 0);
        chk("t4_drop_chkcnt", bus.check_count, 5);
        chk("t4_drop_err", bus.err, 0);
        errs = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            errs += int'(bus.err) + int'(bus.armed);
        end
        chk("t4_idle_quiet", errs, 0);
        chk("t4_idle_chkcnt", bus.check_count, 5);
        chk("t4_idle_errcnt", bus.err_count, 2);
        bus.en = 1'b1;
        step();
        chk("t4_reen_armed0", bus.armed, 0);
        step();
        chk("t4_reen_armed1", bus.armed, 1);
        chk("t4_reen_sync_err", bus.err, 0);
        step();
        chk("t4_reen_check_err", bus.err, 0);
        chk("t4_reen_chkcnt", bus.check_count, 6);
        chk("t4_reen_errcnt", bus.err_count, 2);
        bus.j = 1'b1; bus.k = 1'b0; bus3.en = 1'b1;
        for (int i = 0; i < 15; i++) step();
        chk("t5_errcnt_sat", bus3.err_count, 7);
        chk("t5_chkcnt_sat", bus3.check_count, 7);
        chk("t5_err", bus3.err, 1);
        chk("t5_code", bus3.err_code, 1);
        chk("t5_sticky", bus3.err_sticky, 1);
        chk("t5_main_errcnt", bus.err_count, 2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
